alu_control_unit: RTL and testbench

- Pipelined successor to the combinational ALU decoder.
- Decodes the data-processing fields (alu_op, s, cmd) together with the condition field (cond), and carries the decoded controls through PIPE_DEPTH register stages with valid/stall/flush.
- Holds the architectural NZCV flag register. Evaluates cond against NZCV at the output stage and gates register and flag writes.
- Sits between instruction decode and the ALU/register-file write-back in the CPU datapath.

---
 rtl/alu_pkg.sv | 78 +++++++
 rtl/alu_control_unit_if.sv | 37 +++
 rtl/alu_cmd_decoder.sv | 49 ++++
 rtl/alu_control_unit.sv | 115 +++++++++++
 tb/tb_alu_control_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU control unit.
// Contents: data-processing opcode constants, ALU control and condition
// encodings, NZCV bit positions, the control word staged down the pipe,
// and the condition-code evaluator.
package alu_pkg;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_SBC = 4'b0110;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_ADC  = 3'b100,
    ALU_SBC  = 3'b101,
    ALU_EOR  = 3'b110,
    ALU_RSVD = 3'b111
  } alu_ctl_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    alu_ctl_t   ctl;
    logic       shift;
    logic       no_write;
    logic [1:0] flag_w;
    logic       illegal;
    cond_t      cond;
    logic       reg_w;
  } ctrl_t;

  function automatic logic cond_pass(input cond_t c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cf = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = cf;
      COND_CC: cond_pass = ~cf;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = cf & ~z;
      COND_LS: cond_pass = ~cf | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      default: cond_pass = 1'b1;  // AL and 1111 both execute
    endcase
  endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// Bus between instruction decode / ALU and the ALU control unit.
// Inputs to the unit: valid_i, alu_op, s, cmd, cond, reg_w_i, stall, flush,
// alu_flags. Outputs from the unit: valid_o, alu_ctl, shift, no_write,
// flag_w, illegal, cond_ex, reg_write, flags.
// master = the decode/datapath side, slave = the control unit.
interface alu_control_unit_if;
  logic       valid_i;
  logic       alu_op;
  logic       s;
  logic [3:0] cmd;
  logic [3:0] cond;
  logic       reg_w_i;
  logic       stall;
  logic       flush;
  logic [3:0] alu_flags;
  logic       valid_o;
  logic [2:0] alu_ctl;
  logic       shift;
  logic       no_write;
  logic [1:0] flag_w;
  logic       illegal;
  logic       cond_ex;
  logic       reg_write;
  logic [3:0] flags;

  modport master (
    output valid_i, alu_op, s, cmd, cond, reg_w_i, stall, flush, alu_flags,
    input  valid_o, alu_ctl, shift, no_write, flag_w, illegal, cond_ex,
           reg_write, flags
  );

  modport slave (
    input  valid_i, alu_op, s, cmd, cond, reg_w_i, stall, flush, alu_flags,
    output valid_o, alu_ctl, shift, no_write, flag_w, illegal, cond_ex,
           reg_write, flags
  );
endinterface

// File: rtl/alu_cmd_decoder.sv
// Combinational decode of the data-processing fields.
// Inputs: alu_op (1 = data-processing, 0 = address add), s (set flags),
// cmd (opcode). Outputs: ctl, shift, no_write, flag_w, illegal.
module alu_cmd_decoder
  import alu_pkg::*;
(
  input  logic       alu_op,
  input  logic       s,
  input  logic [3:0] cmd,
  output alu_ctl_t   ctl,
  output logic       shift,
  output logic       no_write,
  output logic [1:0] flag_w,
  output logic       illegal
);

  logic [1:0] fw_arith;
  logic [1:0] fw_logic;

  assign fw_arith = s ? 2'b11 : 2'b00;
  assign fw_logic = s ? 2'b10 : 2'b00;

  always_comb begin
    ctl      = ALU_ADD;
    shift    = 1'b0;
    no_write = 1'b0;
    flag_w   = 2'b00;
    illegal  = 1'b0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin ctl = ALU_ADD; flag_w = fw_arith; end
        CMD_SUB: begin ctl = ALU_SUB; flag_w = fw_arith; end
        CMD_ADC: begin ctl = ALU_ADC; flag_w = fw_arith; end
        CMD_SBC: begin ctl = ALU_SBC; flag_w = fw_arith; end
        CMD_AND: begin ctl = ALU_AND; flag_w = fw_logic; end
        CMD_ORR: begin ctl = ALU_ORR; flag_w = fw_logic; end
        CMD_EOR: begin ctl = ALU_EOR; flag_w = fw_logic; end
        CMD_MOV: begin ctl = ALU_ADD; shift = 1'b1; flag_w = fw_logic; end
        // compare/test forms always set flags and never write Rd
        CMD_CMP: begin ctl = ALU_SUB; no_write = 1'b1; flag_w = 2'b11; end
        CMD_CMN: begin ctl = ALU_ADD; no_write = 1'b1; flag_w = 2'b11; end
        CMD_TST: begin ctl = ALU_AND; no_write = 1'b1; flag_w = 2'b10; end
        CMD_TEQ: begin ctl = ALU_EOR; no_write = 1'b1; flag_w = 2'b10; end
        default: begin illegal = 1'b1; no_write = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/alu_control_unit.sv
// Pipelined ALU control unit. Decodes alu_op/s/cmd/cond at the input,
// carries the control word through PIPE_DEPTH stages with valid, stall
// and flush, and owns the NZCV register. At the output stage the
// condition is evaluated against NZCV, gating Rd and flag writes.
// Ports: clk, reset (async, active high), bus (slave side of
// alu_control_unit_if).
module alu_control_unit
  import alu_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH  = 1,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  alu_control_unit_if.slave   bus
);

  alu_ctl_t   dec_ctl;
  logic       dec_shift;
  logic       dec_no_write;
  logic [1:0] dec_flag_w;
  logic       dec_illegal;
  ctrl_t      ctrl_in;

  logic       valid_q [PIPE_DEPTH];
  logic       valid_d [PIPE_DEPTH];
  ctrl_t      ctrl_q  [PIPE_DEPTH];
  ctrl_t      ctrl_d  [PIPE_DEPTH];
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  ctrl_t      ctrl_out;
  logic       valid_out;
  logic       cond_ok;
  logic       flag_wr;

  alu_cmd_decoder u_dec (
    .alu_op   (bus.alu_op),
    .s        (bus.s),
    .cmd      (bus.cmd),
    .ctl      (dec_ctl),
    .shift    (dec_shift),
    .no_write (dec_no_write),
    .flag_w   (dec_flag_w),
    .illegal  (dec_illegal)
  );

  always_comb begin
    ctrl_in          = '0;
    ctrl_in.ctl      = dec_ctl;
    ctrl_in.shift    = dec_shift;
    ctrl_in.no_write = dec_no_write;
    ctrl_in.flag_w   = dec_flag_w;
    ctrl_in.illegal  = dec_illegal;
    ctrl_in.cond     = cond_t'(bus.cond);
    ctrl_in.reg_w    = bus.reg_w_i;
  end

  // flush wins over stall; staged fields are left as-is on flush since
  // every consumer is gated by the stage valid.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (bus.flush) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) valid_d[i] = 1'b0;
    end else if (!bus.stall) begin
      valid_d[0] = bus.valid_i;
      ctrl_d[0]  = ctrl_in;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        ctrl_d[i]  = ctrl_q[i-1];
      end
    end
  end

  assign ctrl_out  = ctrl_q[PIPE_DEPTH-1];
  assign valid_out = valid_q[PIPE_DEPTH-1];
  assign cond_ok   = cond_pass(ctrl_out.cond, flags_q);
  assign flag_wr   = valid_out & ~bus.stall & ~bus.flush & cond_ok &
                     ~ctrl_out.illegal;

  always_comb begin
    flags_d = flags_q;
    if (flag_wr && ctrl_out.flag_w[1]) flags_d[3:2] = bus.alu_flags[3:2];
    if (flag_wr && ctrl_out.flag_w[0]) flags_d[1:0] = bus.alu_flags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= '0;
      end
      flags_q <= RESET_FLAGS;
    end else begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        ctrl_q[i]  <= ctrl_d[i];
      end
      flags_q <= flags_d;
    end
  end

  assign bus.valid_o   = valid_out;
  assign bus.alu_ctl   = ctrl_out.ctl;
  assign bus.shift     = ctrl_out.shift;
  assign bus.no_write  = ctrl_out.no_write;
  assign bus.flag_w    = ctrl_out.flag_w;
  assign bus.illegal   = ctrl_out.illegal;
  assign bus.cond_ex   = cond_ok;
  assign bus.reg_write = valid_out & cond_ok & ctrl_out.reg_w &
                         ~ctrl_out.no_write & ~ctrl_out.illegal;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit with PIPE_DEPTH = 2.
// Issued instructions go into a scoreboard queue; each retiring output
// is popped and compared against an independent decode table, condition
// evaluator and NZCV model. Directed checks cover latency, hazards,
// stall, flush and asynchronous reset.
module tb_alu_control_unit;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic       op;
    logic       s;
    logic [3:0] cmd;
    logic [3:0] cond;
    logic       regw;
  } item_t;

  logic clk;
  logic reset;
  alu_control_unit_if bus ();

  alu_control_unit #(.PIPE_DEPTH(DEPTH), .RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  item_t sb[$];
  logic [3:0] mflags = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {illegal, shift, no_write, flag_w[1:0], ctl[2:0]}
  function automatic logic [7:0] ref_dec(input logic op, input logic s, input logic [3:0] cmd);
    logic [1:0] fa, fl;
    fa = s ? 2'b11 : 2'b00;
    fl = s ? 2'b10 : 2'b00;
    if (!op) return 8'b0;
    case (cmd)
      4'b0100: return {3'b000, fa,    3'b000};
      4'b0010: return {3'b000, fa,    3'b001};
      4'b0101: return {3'b000, fa,    3'b100};
      4'b0110: return {3'b000, fa,    3'b101};
      4'b0000: return {3'b000, fl,    3'b010};
      4'b1100: return {3'b000, fl,    3'b011};
      4'b0001: return {3'b000, fl,    3'b110};
      4'b1101: return {3'b010, fl,    3'b000};
      4'b1010: return {3'b001, 2'b11, 3'b001};
      4'b1011: return {3'b001, 2'b11, 3'b000};
      4'b1000: return {3'b001, 2'b10, 3'b010};
      4'b1001: return {3'b001, 2'b10, 3'b110};
      default: return {3'b101, 2'b00, 3'b000};
    endcase
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'd0:  return f[2];
      4'd1:  return !f[2];
      4'd2:  return f[1];
      4'd3:  return !f[1];
      4'd4:  return f[3];
      4'd5:  return !f[3];
      4'd6:  return f[0];
      4'd7:  return !f[0];
      4'd8:  return f[1] && !f[2];
      4'd9:  return !f[1] || f[2];
      4'd10: return f[3] == f[0];
      4'd11: return f[3] != f[0];
      4'd12: return !f[2] && (f[3] == f[0]);
      4'd13: return f[2] || (f[3] != f[0]);
      default: return 1'b1;
    endcase
  endfunction

  // Scoreboard: push on capture, pop and compare on retire.
  always @(negedge clk) begin
    item_t      it;
    logic [7:0] e;
    logic       pass;
    if (reset) begin
      sb.delete();
      mflags = 4'b0000;
    end else begin
      chk("flags", 32'(bus.flags), 32'(mflags));
      if (bus.flush) begin
        sb.delete();
      end else if (!bus.stall) begin
        if (bus.valid_o) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            it   = sb.pop_front();
            e    = ref_dec(it.op, it.s, it.cmd);
            pass = ref_cond(it.cond, mflags);
            chk("alu_ctl",   32'(bus.alu_ctl),   32'(e[2:0]));
            chk("flag_w",    32'(bus.flag_w),    32'(e[4:3]));
            chk("no_write",  32'(bus.no_write),  32'(e[5]));
            chk("shift",     32'(bus.shift),     32'(e[6]));
            chk("illegal",   32'(bus.illegal),   32'(e[7]));
            chk("cond_ex",   32'(bus.cond_ex),   32'(pass));
            chk("reg_write", 32'(bus.reg_write),
                32'(pass & it.regw & ~e[5] & ~e[7]));
            if (pass && e[4]) mflags[3:2] = bus.alu_flags[3:2];
            if (pass && e[3]) mflags[1:0] = bus.alu_flags[1:0];
          end
        end
        if (bus.valid_i)
          sb.push_back('{op: bus.alu_op, s: bus.s, cmd: bus.cmd,
                         cond: bus.cond, regw: bus.reg_w_i});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic s, input logic [3:0] cmd,
                       input logic [3:0] cond, input logic regw);
    bus.valid_i = 1'b1;
    bus.alu_op  = op;
    bus.s       = s;
    bus.cmd     = cmd;
    bus.cond    = cond;
    bus.reg_w_i = regw;
  endtask

  // Issue one instruction with alu_flags held until it has retired.
  task automatic issue_wait(input logic op, input logic s, input logic [3:0] cmd,
                            input logic [3:0] cond, input logic [3:0] af);
    bus.alu_flags = af;
    drive(op, s, cmd, cond, 1'b1);
    step();
    bus.valid_i = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.valid_i = 1'b0; bus.alu_op = 1'b0; bus.s = 1'b0; bus.cmd = '0;
    bus.cond = '0; bus.reg_w_i = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.alu_flags = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid_o",  32'(bus.valid_o),   32'd0);
    chk("rst_alu_ctl",  32'(bus.alu_ctl),   32'd0);
    chk("rst_shift",    32'(bus.shift),     32'd0);
    chk("rst_no_write", 32'(bus.no_write),  32'd0);
    chk("rst_flag_w",   32'(bus.flag_w),    32'd0);
    chk("rst_illegal",  32'(bus.illegal),   32'd0);
    chk("rst_reg_write",32'(bus.reg_write), 32'd0);
    chk("rst_flags",    32'(bus.flags),     32'd0);
    chk("rst_cond_ex",  32'(bus.cond_ex),   32'd0);  // EQ on Z=0
    @(posedge clk); #1 reset = 1'b0;

    // Latency: ADD s=1 AL appears exactly DEPTH cycles after capture.
    bus.alu_flags = 4'b0110;
    drive(1'b1, 1'b1, 4'b0100, 4'b1110, 1'b1);
    step();
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 32'(bus.valid_o), 32'd0);
    step();
    @(negedge clk);
    chk("lat_valid",     32'(bus.valid_o),   32'd1);
    chk("lat_alu_ctl",   32'(bus.alu_ctl),   32'd0);
    chk("lat_flag_w",    32'(bus.flag_w),    32'd3);
    chk("lat_reg_write", 32'(bus.reg_write), 32'd1);
    step();
    @(negedge clk);
    chk("lat_flags", 32'(bus.flags), 32'h6);

    // Back-to-back decode sweep with random cond, reg_w and ALU flags.
    for (int op = 0; op < 2; op++)
      for (int sv = 0; sv < 2; sv++)
        for (int c = 0; c < 16; c++) begin
          bus.alu_flags = 4'($urandom_range(0, 15));
          drive(1'(op), 1'(sv), 4'(c), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
          step();
        end
    bus.valid_i = 1'b0;
    repeat (3) step();

    // Illegal opcode in isolation.
    issue_wait(1'b1, 1'b1, 4'b0111, 4'b1110, 4'b1111);

    // CMP sets Z; then CMP clears it and a dependent EQ in the next slot fails.
    issue_wait(1'b1, 1'b0, 4'b1010, 4'b1110, 4'b0100);
    @(negedge clk);
    chk("cmp_flags", 32'(bus.flags), 32'h4);
    bus.alu_flags = 4'b0000;
    drive(1'b1, 1'b0, 4'b1010, 4'b1110, 1'b1);
    step();
    drive(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1);
    step();
    bus.valid_i = 1'b0;
    step();
    bus.alu_flags = 4'b1111;
    @(negedge clk);
    chk("eq_cond_ex",   32'(bus.cond_ex),   32'd0);
    chk("eq_reg_write", 32'(bus.reg_write), 32'd0);
    repeat (2) step();
    @(negedge clk);
    chk("eq_flags", 32'(bus.flags), 32'h0);

    // Same ADD with NE passes on Z=0.
    drive(1'b1, 1'b0, 4'b0100, 4'b0001, 1'b1);
    step();
    bus.valid_i = 1'b0;
    step();
    @(negedge clk);
    chk("ne_cond_ex",   32'(bus.cond_ex),   32'd1);
    chk("ne_reg_write", 32'(bus.reg_write), 32'd1);
    repeat (2) step();

    // AND s=1 updates N,Z only.
    issue_wait(1'b1, 1'b0, 4'b1010, 4'b1110, 4'b0011);
    issue_wait(1'b1, 1'b1, 4'b0000, 4'b1110, 4'b1000);
    @(negedge clk);
    chk("and_flags", 32'(bus.flags), 32'hB);

    // Stall with the output stage occupied.
    bus.alu_flags = 4'b0101;
    drive(1'b1, 1'b1, 4'b0100, 4'b1110, 1'b1);
    step();
    bus.valid_i = 1'b0;
    step();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.alu_flags = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("stall_valid",   32'(bus.valid_o), 32'd1);
      chk("stall_alu_ctl", 32'(bus.alu_ctl), 32'd0);
      chk("stall_flag_w",  32'(bus.flag_w),  32'd3);
      chk("stall_flags",   32'(bus.flags),   32'hB);
      step();
    end
    bus.stall = 1'b0;
    bus.alu_flags = 4'b0101;
    step();
    @(negedge clk);
    chk("release_flags", 32'(bus.flags), 32'h5);
    step();

    // Flush together with stall while two instructions are in flight.
    bus.alu_flags = 4'b1111;
    drive(1'b1, 1'b1, 4'b0100, 4'b1110, 1'b1);
    step();
    drive(1'b1, 1'b1, 4'b0010, 4'b1110, 1'b1);
    step();
    bus.valid_i = 1'b0;
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(bus.valid_o), 32'd0);
    chk("flush_flags", 32'(bus.flags),   32'h5);
    repeat (3) step();
    @(negedge clk);
    chk("flush_drain_valid", 32'(bus.valid_o), 32'd0);
    chk("flush_drain_flags", 32'(bus.flags),   32'h5);

    // Asynchronous reset mid-stream.
    bus.alu_flags = 4'b1010;
    drive(1'b1, 1'b1, 4'b0100, 4'b1110, 1'b1);
    step();
    drive(1'b1, 1'b1, 4'b1100, 4'b1110, 1'b1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid",     32'(bus.valid_o),   32'd0);
    chk("arst_flags",     32'(bus.flags),     32'h0);
    chk("arst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("arst_alu_ctl",   32'(bus.alu_ctl),   32'd0);
    chk("arst_flag_w",    32'(bus.flag_w),    32'd0);
    bus.valid_i = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("final_valid", 32'(bus.valid_o), 32'd0);
    chk("sb_empty",    32'(sb.size()),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
